// File: rtl/fft_spectrum_sink_pkg.sv
// Shared constants, FSM state type and helpers for the FFT spectrum sink.
package fft_spectrum_sink_pkg;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned NFFT    = 1024;
  localparam int unsigned IDX_W   = $clog2(NFFT);
  localparam int unsigned MAG_W   = WIDTH + 1;
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned PEAK_LO = 1;
  localparam int unsigned PEAK_HI = NFFT / 2 - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Absolute value as an unsigned WIDTH-bit number; the most negative input
  // maps to 2**(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/fft_spectrum_sink_spectrum_dpram.sv
// Spectrum buffer: 2*NFFT x MAG_W simple dual-port RAM. Address MSB selects
// the bank. One write port, one synchronous read port (read-first).
//   clk          clock
//   we/waddr/wdata  write port
//   re/raddr     read strobe and address
//   rdata        registered read data, holds when re is low
module spectrum_dpram
  import fft_spectrum_sink_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W:0]   waddr,
  input  logic [MAG_W-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W:0]   raddr,
  output logic [MAG_W-1:0] rdata
);

  logic [MAG_W-1:0] mem [2*NFFT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_spectrum_sink.sv
// FFT unload-stream consumer. Converts each beat to |re|+|im|, stores it in a
// ping-pong spectrum buffer, tracks the peak bin, and publishes complete
// frames to a host read port.
//   clk, rst_n                      clock, async active-low reset
//   data_soud/data_opd/data_eoud    unload framing: start, beat valid, end
//   idx, xk_re, xk_im               bin index and signed bin value
//   rd_en, rd_addr                  host read strobe / bin
//   rd_data, rd_valid               read result, 1-cycle latency
//   frame_done, frame_err           one-cycle publish / reject pulses
//   frame_valid                     a frame has been published since reset
//   peak_idx, peak_mag              peak of the published frame
//   busy                            capture or finish in progress
module fft_spectrum_sink
  import fft_spectrum_sink_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_soud,
  input  logic             data_opd,
  input  logic             data_eoud,
  input  logic [IDX_W-1:0] idx,
  input  logic [WIDTH-1:0] xk_re,
  input  logic [WIDTH-1:0] xk_im,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [MAG_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             frame_done,
  output logic             frame_err,
  output logic             frame_valid,
  output logic [IDX_W-1:0] peak_idx,
  output logic [MAG_W-1:0] peak_mag,
  output logic             busy
);

  state_t           state, state_nx;
  logic [1:0]       fin_cnt;
  logic             wbank, rbank;
  logic [CNT_W-1:0] beat_cnt;
  logic [MAG_W-1:0] run_max;
  logic [IDX_W-1:0] run_idx;

  logic             s1_vld, s1_first;
  logic [IDX_W-1:0] s1_idx;
  logic [WIDTH-1:0] s1_are, s1_aim;

  logic             capture;
  logic [MAG_W-1:0] mag;
  logic             in_range, finishing, publish, wr_bank, rd_zero;
  logic [MAG_W-1:0] ram_q;

  assign capture = data_opd && (data_soud || state == CAPT);

  always_comb begin
    mag       = MAG_W'(s1_are) + MAG_W'(s1_aim);
    in_range  = (s1_idx >= IDX_W'(PEAK_LO)) && (s1_idx <= IDX_W'(PEAK_HI));
    // Finish is tracked by fin_cnt rather than state, so a new data_soud
    // arriving during FIN can move the FSM back to CAPT without losing the
    // pending publish of the previous frame.
    finishing = (fin_cnt == 2'd1);
    publish   = finishing && (beat_cnt == CNT_W'(NFFT));
    // A beat written on the swap edge belongs to the next frame, so it must
    // already target the post-swap write bank.
    wr_bank   = publish ? ~wbank : wbank;
    rd_data   = rd_zero ? '0 : ram_q;

    state_nx = state;
    unique case (state)
      IDLE:    if (data_soud) state_nx = CAPT;
      CAPT:    if (data_eoud) state_nx = FIN;
      FIN:     if (data_soud) state_nx = CAPT;
               else if (finishing) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage 1: register absolute values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_first <= 1'b0;
      s1_idx   <= '0;
      s1_are   <= '0;
      s1_aim   <= '0;
    end else begin
      s1_vld   <= capture;
      s1_first <= capture && data_soud;
      s1_idx   <= idx;
      s1_are   <= abs_val(xk_re);
      s1_aim   <= abs_val(xk_im);
    end
  end

  // FSM, stage 2 (count/peak), bank pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fin_cnt     <= '0;
      wbank       <= 1'b0;
      rbank       <= 1'b1;
      beat_cnt    <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
      peak_idx    <= '0;
      peak_mag    <= '0;
      busy        <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != IDLE) || finishing;
      frame_done <= publish;
      frame_err  <= finishing && !publish;

      if (state == CAPT && data_eoud) fin_cnt <= 2'd2;
      else if (fin_cnt != 2'd0)       fin_cnt <= fin_cnt - 2'd1;

      if (publish) begin
        rbank       <= wbank;
        wbank       <= ~wbank;
        peak_idx    <= run_idx;
        peak_mag    <= run_max;
        frame_valid <= 1'b1;
      end

      if (s1_vld) begin
        if (s1_first) begin
          beat_cnt <= CNT_W'(1);
          run_max  <= in_range ? mag : '0;
          run_idx  <= in_range ? s1_idx : '0;
        end else begin
          if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
          if (in_range && mag > run_max) begin
            run_max <= mag;
            run_idx <= s1_idx;
          end
        end
      end
    end
  end

  // Host read side: reads before the first publish return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_zero <= !frame_valid;
    end
  end

  spectrum_dpram u_ram (
    .clk   (clk),
    .we    (s1_vld),
    .waddr ({wr_bank, s1_idx}),
    .wdata (mag),
    .re    (rd_en),
    .raddr ({rbank, rd_addr}),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_fft_spectrum_sink.sv
// Scoreboard bench for fft_spectrum_sink: stimulus pushes expected frame
// events and read data into queues; a monitor pops and compares.
module tb_fft_spectrum_sink;
  import fft_spectrum_sink_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             data_soud = 1'b0, data_opd = 1'b0, data_eoud = 1'b0;
  logic [IDX_W-1:0] idx = '0;
  logic [WIDTH-1:0] xk_re = '0, xk_im = '0;
  logic             rd_en = 1'b0;
  logic [IDX_W-1:0] rd_addr = '0;
  logic [MAG_W-1:0] rd_data;
  logic             rd_valid, frame_done, frame_err, frame_valid, busy;
  logic [IDX_W-1:0] peak_idx;
  logic [MAG_W-1:0] peak_mag;

  fft_spectrum_sink dut (
    .clk(clk), .rst_n(rst_n),
    .data_soud(data_soud), .data_opd(data_opd), .data_eoud(data_eoud),
    .idx(idx), .xk_re(xk_re), .xk_im(xk_im),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .frame_done(frame_done), .frame_err(frame_err), .frame_valid(frame_valid),
    .peak_idx(peak_idx), .peak_mag(peak_mag), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit done;
    int pidx;
    int pmag;
    int cyc;
  } evt_t;

  evt_t eq[$];
  int   rq[$];
  int   re_v[NFFT];
  int   im_v[NFFT];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bins();
    for (int i = 0; i < NFFT; i++) begin
      re_v[i] = 0;
      im_v[i] = 0;
    end
  endtask

  task automatic send_frame(input int n, input bit with_eoud, input int rd_beat,
                            input int rd_a, input int rd_exp, output int eoud_cyc);
    eoud_cyc = -1;
    for (int i = 0; i < n; i++) begin
      data_opd  = 1'b1;
      data_soud = (i == 0);
      data_eoud = with_eoud && (i == n - 1);
      idx       = IDX_W'(i);
      xk_re     = WIDTH'(re_v[i]);
      xk_im     = WIDTH'(im_v[i]);
      if (i == rd_beat) begin
        rd_en   = 1'b1;
        rd_addr = IDX_W'(rd_a);
        rq.push_back(rd_exp);
      end
      if (data_eoud) eoud_cyc = cyc;
      tick();
      rd_en = 1'b0;
    end
    data_opd  = 1'b0;
    data_soud = 1'b0;
    data_eoud = 1'b0;
    xk_re     = '0;
    xk_im     = '0;
  endtask

  task automatic expect_evt(input bit done, input int pidx, input int pmag, input int ec);
    evt_t e;
    e.done = done;
    e.pidx = pidx;
    e.pmag = pmag;
    e.cyc  = ec + 3;
    eq.push_back(e);
  endtask

  task automatic do_read(input int a, input int exp);
    rd_en   = 1'b1;
    rd_addr = IDX_W'(a);
    rq.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  evt_t me;
  int   mr;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (frame_done || frame_err) begin
        check("frame_evt_expected", int'(eq.size() > 0), 1);
        if (eq.size() > 0) begin
          me = eq.pop_front();
          check("evt_done", int'(frame_done), int'(me.done));
          check("evt_err", int'(frame_err), int'(!me.done));
          check("evt_cycle", cyc, me.cyc);
          check("peak_idx", int'(peak_idx), me.pidx);
          check("peak_mag", int'(peak_mag), me.pmag);
        end
      end
      if (rd_valid) begin
        check("read_expected", int'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          mr = rq.pop_front();
          check("rd_data", int'(rd_data), mr);
        end
      end
    end
  end

  initial begin
    wait (cyc > 30000);
    bad++;
    $display("FAIL watchdog actual=%0d required<=30000 cycles", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  int ec, ec2;

  initial begin
    clear_bins();
    repeat (3) tick();
    check("rst_frame_valid", int'(frame_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_peak_idx", int'(peak_idx), 0);
    check("rst_peak_mag", int'(peak_mag), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();
    do_read(37, 0);

    // Single tone
    clear_bins();
    re_v[37] = 1000;
    send_frame(1024, 1'b1, -1, 0, 0, ec);
    expect_evt(1'b1, 37, 1000, ec);
    check("busy_after_eoud", int'(busy), 1);
    repeat (6) tick();
    check("busy_cleared", int'(busy), 0);
    check("frame_valid_set", int'(frame_valid), 1);
    do_read(37, 1000);
    do_read(36, 0);

    // Extremes
    clear_bins();
    re_v[5] = -32768;
    im_v[5] = -32768;
    send_frame(1024, 1'b1, -1, 0, 0, ec);
    expect_evt(1'b1, 5, 65536, ec);
    repeat (6) tick();
    do_read(5, 65536);
    do_read(37, 0);

    // Peak range and ties
    clear_bins();
    re_v[0]   = 9000;
    re_v[10]  = 500;
    im_v[20]  = -500;
    re_v[600] = 8000;
    send_frame(1024, 1'b1, -1, 0, 0, ec);
    expect_evt(1'b1, 10, 500, ec);
    repeat (6) tick();
    do_read(0, 9000);
    do_read(20, 500);
    do_read(600, 8000);

    // Short frame: rejected, prior frame stays published
    clear_bins();
    re_v[10] = 7777;
    send_frame(1000, 1'b1, -1, 0, 0, ec);
    expect_evt(1'b0, 10, 500, ec);
    repeat (6) tick();
    do_read(10, 500);
    do_read(0, 9000);

    // Ping-pong, including reads around the swap edge
    clear_bins();
    re_v[3] = 111;
    send_frame(1024, 1'b1, -1, 0, 0, ec);
    expect_evt(1'b1, 3, 111, ec);
    repeat (6) tick();
    clear_bins();
    re_v[3] = 222;
    send_frame(1024, 1'b1, 600, 3, 111, ec);
    expect_evt(1'b1, 3, 222, ec);
    do_read(3, 111);
    do_read(3, 111);
    do_read(3, 222);
    repeat (6) tick();

    // Abort/restart, then a frame starting during FIN
    clear_bins();
    re_v[50] = 5000;
    send_frame(500, 1'b0, -1, 0, 0, ec);
    clear_bins();
    re_v[77] = 4321;
    send_frame(1024, 1'b1, -1, 0, 0, ec);
    expect_evt(1'b1, 77, 4321, ec);
    clear_bins();
    re_v[0]   = 1234;
    re_v[200] = 250;
    send_frame(1024, 1'b1, -1, 0, 0, ec2);
    expect_evt(1'b1, 200, 250, ec2);
    repeat (6) tick();
    do_read(0, 1234);
    do_read(200, 250);
    do_read(77, 0);
    do_read(50, 0);

    // Reset mid-capture
    clear_bins();
    re_v[40] = 999;
    send_frame(300, 1'b0, -1, 0, 0, ec);
    check("busy_mid_capture", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_frame_valid", int'(frame_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_peak_mag", int'(peak_mag), 0);
    check("midrst_peak_idx", int'(peak_idx), 0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("postrst_frame_valid", int'(frame_valid), 0);
    do_read(40, 0);
    repeat (3) tick();

    check("evt_queue_empty", eq.size(), 0);
    check("read_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_spectrum_sink.md
# fft_spectrum_sink

Consumer for the FFT core's unload stream (data_soud / data_opd / data_eoud, idx, xk_re, xk_im). Each beat is converted to an L1 magnitude, |re|+|im|, and written into a ping-pong spectrum buffer. The block tracks the peak bin during capture. A completed frame is published to a synchronous host read port and announced with a one-cycle done pulse. It sits directly downstream of FFT_TOP, in place of the testbench observer.

## Interface
- WIDTH, 16: FFT output component width (signed).
- NFFT, 1024: frame length; IDX_W = log2(NFFT) = 10.
- MAG_W, WIDTH+1 = 17: magnitude width.
- PEAK_LO, 1: lowest bin included in the peak search; the search ends at NFFT/2-1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_soud  in  1  first unload beat; coincides with the first data_opd.
- data_opd  in  1  beat valid.
- data_eoud  in  1  end of unload; coincides with or follows the last beat.
- idx  in  IDX_W  bin index of the beat.
- xk_re, xk_im  in  WIDTH  signed bin value.
- rd_en  in  1  host read strobe.
- rd_addr  in  IDX_W  host read bin.
- rd_data  out  MAG_W  magnitude of the published frame.
- rd_valid  out  1  rd_data valid.
- frame_done  out  1  one-cycle pulse: new frame published.
- frame_err  out  1  one-cycle pulse: frame rejected.
- frame_valid  out  1  at least one frame published since reset.
- peak_idx  out  IDX_W  peak bin of the published frame.
- peak_mag  out  MAG_W  peak magnitude of the published frame.
- busy  out  1  capture in progress.

## Operation
- FSM states: IDLE, CAPT, FIN.
  - IDLE → CAPT on data_soud.
  - CAPT → FIN on data_eoud.
  - FIN → IDLE after the pipeline drains (2 cycles).
- Magnitude: mag = |xk_re| + |xk_im|, both zero-extended to MAG_W. Nothing saturates. -32768 gives 32768, so the maximum mag is 65536.
- In CAPT, each data_opd beat:
  - writes mag to address idx of the write bank (wbank);
  - increments beat_cnt;
  - if PEAK_LO ≤ idx ≤ NFFT/2-1 and mag > run_max (strictly greater), updates run_max and run_idx. Ties keep the earlier beat.
- The data_soud beat is itself captured. It resets beat_cnt to 1 and run_max/run_idx to that beat's contribution, or to 0 if the beat is outside the search range.
- FIN when beat_cnt == NFFT:
  - rbank ← wbank; wbank flips;
  - peak_idx/peak_mag ← run_idx/run_max;
  - frame_valid ← 1; frame_done pulses.
- FIN when beat_cnt ≠ NFFT:
  - frame_err pulses;
  - no swap; peak outputs and rbank are unchanged.
- data_soud while in CAPT: the partial frame is discarded without an error, and capture restarts with this beat.
- data_opd in IDLE is ignored.
- data_eoud in IDLE is ignored.
- Host reads always address rbank. Writes never target rbank, so reads during capture return the previous frame.
- rd_en before frame_valid returns 0 with rd_valid = 1.

## Timing
- Reset (asynchronous):
  - outputs: all 0;
  - state: IDLE, wbank = 0, rbank = 1, beat_cnt = 0, run_max = 0.
  - RAM contents are not reset.
- Pipeline: stage 1 registers the absolute values; stage 2 sums, writes the RAM and compares. A beat at cycle t is written at edge t+2.
- frame_done / frame_err assert exactly 3 cycles after the data_eoud cycle. peak_* and the swapped rbank are visible in that same cycle.
- Read latency is 1: rd_en at t gives rd_data/rd_valid at t+1. rd_valid is 0 otherwise, and rd_data holds its last value.
- A read in the swap cycle returns the old rbank data. Reads from t+1 onward return the new frame.
- busy = 1 from the cycle after data_soud through the frame_done/frame_err cycle.
- data_soud may arrive while in FIN. The new frame starts in wbank (already flipped) and FIN completes normally.
- rst_n asserted mid-frame: no pulse; frame_valid clears.

## Structure
- Shared package: NFFT, IDX_W, MAG_W, FSM state encoding.
- Sub-module spectrum_dpram: 2·NFFT × MAG_W simple dual-port RAM, one write port and one synchronous read port. The bank bit is the address MSB.
- Top level holds the FSM, magnitude pipeline, peak tracker, beat counter and bank pointers.

## Test plan
- Single tone: xk_re = 1000 at idx 37, all other bins 0, one full frame → frame_done 3 cycles after eoud; peak_idx = 37, peak_mag = 1000; read of addr 37 returns 1000 and addr 36 returns 0.
- Extremes: xk_re = xk_im = -32768 at idx 5 → rd_data = 17'h10000 and peak_mag = 65536.
- Peak range and ties: bin 0 = 9000, bins 10 and 20 = 500, bin 600 = 8000 → peak_idx = 10, peak_mag = 500.
- Short frame: 1000 beats then eoud → frame_err pulse, no frame_done; peak and read data still from the prior good frame.
- Ping-pong: frame A (bin 3 = 111), then frame B (bin 3 = 222); reads during B's capture return 111, reads after B's frame_done return 222.
- Abort and reset:
  - data_soud at beat 500 restarts capture; 1024 further beats → frame_done with correct data.
  - rst_n low mid-capture → no pulse, frame_valid = 0.
